// File: rtl/tcp_tx_route_table.sv
// tcp_tx_route_table
// Session-to-route lookup table for the TCP TX arbiter. A direct-mapped table
// indexed by the low SID bits holds {valid, tag, route} per entry. After reset
// a sweep invalidates every entry. Host logic then programs or deletes entries
// through the cfg_wr_* port. Lookups run through a four-state FSM and answer
// with a one-cycle strobe two cycles after the request is sampled.
//
// Optional feature macro: TCP_ROUTE_STATS_EN
//   defined   -> saturating 32-bit hit/miss counters are built
//   undefined -> stat_hit_cnt / stat_miss_cnt are tied to zero
//
// Lookup handshake: tx_sid_valid is a level. The table samples it in idle,
// answers once with tx_route_id_valid, and then waits for the level to drop
// before it accepts another request. A request that stays high after its
// answer is therefore never served twice. Config writes complete in the cycle
// where cfg_wr_valid && cfg_wr_ready.

`ifndef TCP_SESSION_BITS
`define TCP_SESSION_BITS 16
`endif

module tcp_tx_route_table #(
  parameter int SID_BITS   = `TCP_SESSION_BITS,
  parameter int IDX_BITS   = 10,
  parameter int ROUTE_BITS = 14,
  parameter logic [ROUTE_BITS-1:0] DEFAULT_ROUTE = '0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [SID_BITS-1:0]   tx_sid,
  input  logic                  tx_sid_valid,
  output logic [ROUTE_BITS-1:0] tx_route_id,
  output logic                  tx_route_id_valid,
  output logic                  tx_route_hit,
  input  logic                  cfg_wr_valid,
  output logic                  cfg_wr_ready,
  input  logic [SID_BITS-1:0]   cfg_wr_sid,
  input  logic [ROUTE_BITS-1:0] cfg_wr_route,
  input  logic                  cfg_wr_del,
  output logic                  init_done,
  output logic [31:0]           stat_hit_cnt,
  output logic [31:0]           stat_miss_cnt
);

  localparam int TAG_BITS   = (SID_BITS > IDX_BITS) ? (SID_BITS - IDX_BITS) : 1;
  localparam int DEPTH      = 2 ** IDX_BITS;
  localparam int ENTRY_BITS = 1 + TAG_BITS + ROUTE_BITS;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_READ = 2'd1,
    LK_RSP  = 2'd2,
    LK_HOLD = 2'd3
  } lk_state_t;

  // Upper SID bits. The result is zero when the SID has no bits above the index.
  function automatic logic [TAG_BITS-1:0] tag_of(input logic [SID_BITS-1:0] sid);
    logic [SID_BITS-1:0] hi;
    hi = sid >> IDX_BITS;
    return TAG_BITS'(hi);
  endfunction

  lk_state_t                lk_state;
  logic [ENTRY_BITS-1:0]    mem [DEPTH];
  logic [ENTRY_BITS-1:0]    rd_data;
  logic [ENTRY_BITS-1:0]    rd_q;
  logic [SID_BITS-1:0]      sid_q;
  logic                     rd_pre_init;
  logic [IDX_BITS-1:0]      sweep_idx;
  logic                     wr_en;
  logic [IDX_BITS-1:0]      wr_idx;
  logic [ENTRY_BITS-1:0]    wr_data;
  logic                     rd_en;
  logic                     rd_valid;
  logic [TAG_BITS-1:0]      rd_tag;
  logic [ROUTE_BITS-1:0]    rd_route;
  logic                     rsp_hit;

  assign cfg_wr_ready = init_done;

  // Init sweep: walk every index once after reset, then raise init_done
  always_ff @(posedge aclk) begin
    if (areset) begin
      sweep_idx <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == IDX_BITS'(DEPTH - 1)) begin
        init_done <= 1'b1;
      end
    end
  end

  // Single write port: the sweep owns it until init_done, then config writes
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sweep_idx;
    wr_data = '0;
    if (areset) begin
      wr_en = 1'b0;
    end else if (!init_done) begin
      wr_en = 1'b1;
    end else if (cfg_wr_valid) begin
      wr_en   = 1'b1;
      wr_idx  = cfg_wr_sid[IDX_BITS-1:0];
      wr_data = {!cfg_wr_del, tag_of(cfg_wr_sid), cfg_wr_route};
    end
  end

  // Table RAM write port
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Table RAM read port. A same-edge write to the same index is not seen (read-first).
  assign rd_en = (lk_state == LK_IDLE) && tx_sid_valid;

  always_ff @(posedge aclk) begin
    if (rd_en) begin
      rd_data <= mem[tx_sid[IDX_BITS-1:0]];
    end
  end

  // Compare the registered entry against the SID captured at request time.
  // RAM contents are meaningless before the sweep is done, so those reads always miss.
  assign rd_valid = rd_q[ENTRY_BITS-1];
  assign rd_tag   = rd_q[ROUTE_BITS +: TAG_BITS];
  assign rd_route = rd_q[ROUTE_BITS-1:0];
  assign rsp_hit  = rd_valid && (rd_tag == tag_of(sid_q)) && !rd_pre_init;

  // Lookup FSM with registered response outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      lk_state          <= LK_IDLE;
      sid_q             <= '0;
      rd_pre_init       <= 1'b0;
      rd_q              <= '0;
      tx_route_id       <= '0;
      tx_route_id_valid <= 1'b0;
      tx_route_hit      <= 1'b0;
    end else begin
      tx_route_id_valid <= 1'b0;
      case (lk_state)
        LK_IDLE: begin
          if (tx_sid_valid) begin
            sid_q       <= tx_sid;
            rd_pre_init <= !init_done;
            lk_state    <= LK_READ;
          end
        end
        LK_READ: begin
          rd_q     <= rd_data;
          lk_state <= LK_RSP;
        end
        LK_RSP: begin
          tx_route_id       <= rsp_hit ? rd_route : DEFAULT_ROUTE;
          tx_route_hit      <= rsp_hit;
          tx_route_id_valid <= 1'b1;
          lk_state          <= LK_HOLD;
        end
        LK_HOLD: begin
          if (!tx_sid_valid) begin
            lk_state <= LK_IDLE;
          end
        end
        default: lk_state <= LK_IDLE;
      endcase
    end
  end

`ifdef TCP_ROUTE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Saturating hit/miss counters, stepped once per answered lookup
  always_ff @(posedge aclk) begin
    if (areset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lk_state == LK_RSP) begin
      if (rsp_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign stat_hit_cnt  = hit_cnt;
  assign stat_miss_cnt = miss_cnt;
`else
  assign stat_hit_cnt  = '0;
  assign stat_miss_cnt = '0;
`endif

endmodule

// File: tb/tb_tcp_tx_route_table.sv
// Bench for tcp_tx_route_table: directed scenarios plus randomized traffic,
// checked every cycle against a table/queue model of the lookup service.

module tb_tcp_tx_route_table;

  localparam int SID_BITS   = 16;
  localparam int IDX_BITS   = 10;
  localparam int ROUTE_BITS = 14;
  localparam int DEPTH      = 1 << IDX_BITS;
  localparam logic [ROUTE_BITS-1:0] DEF_ROUTE = '0;
`ifdef TCP_ROUTE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                  aclk;
  logic                  areset;
  logic [SID_BITS-1:0]   tx_sid;
  logic                  tx_sid_valid;
  logic [ROUTE_BITS-1:0] tx_route_id;
  logic                  tx_route_id_valid;
  logic                  tx_route_hit;
  logic                  cfg_wr_valid;
  logic                  cfg_wr_ready;
  logic [SID_BITS-1:0]   cfg_wr_sid;
  logic [ROUTE_BITS-1:0] cfg_wr_route;
  logic                  cfg_wr_del;
  logic                  init_done;
  logic [31:0]           stat_hit_cnt;
  logic [31:0]           stat_miss_cnt;

  tcp_tx_route_table #(
    .SID_BITS(SID_BITS), .IDX_BITS(IDX_BITS), .ROUTE_BITS(ROUTE_BITS),
    .DEFAULT_ROUTE(DEF_ROUTE)
  ) dut (
    .aclk(aclk), .areset(areset),
    .tx_sid(tx_sid), .tx_sid_valid(tx_sid_valid),
    .tx_route_id(tx_route_id), .tx_route_id_valid(tx_route_id_valid),
    .tx_route_hit(tx_route_hit),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_sid(cfg_wr_sid), .cfg_wr_route(cfg_wr_route), .cfg_wr_del(cfg_wr_del),
    .init_done(init_done),
    .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Table of entries, queue of pending answers, and the service phase of the lookup port.
  bit                    t_valid [DEPTH];
  int unsigned           t_tag   [DEPTH];
  logic [ROUTE_BITS-1:0] t_route [DEPTH];
  logic [ROUTE_BITS:0]   exp_q[$];
  int                    due_q[$];
  typedef enum {P_FREE, P_BUSY, P_WAITLOW} phase_t;
  phase_t                phase = P_FREE;
  bit                    m_done = 1'b0;
  int                    m_sweep = 0;
  logic                  e_valid = 1'b0;
  logic [ROUTE_BITS-1:0] e_route = '0;
  logic                  e_hit = 1'b0;
  logic [31:0]           m_hit = '0;
  logic [31:0]           m_miss = '0;
  logic [ROUTE_BITS-1:0] m_last_route = '0;
  logic                  m_last_hit = 1'b0;

  always @(posedge aclk) begin : model
    int unsigned idx, tag;
    logic [ROUTE_BITS:0] r;
    bit h;
    cyc++;
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) t_valid[i] = 1'b0;
      exp_q.delete();
      due_q.delete();
      phase   = P_FREE;
      m_done  = 1'b0;
      m_sweep = 0;
      e_valid = 1'b0;
      e_route = '0;
      e_hit   = 1'b0;
      m_hit   = '0;
      m_miss  = '0;
    end else begin
      e_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        r = exp_q.pop_front();
        void'(due_q.pop_front());
        e_valid = 1'b1;
        e_hit   = r[ROUTE_BITS];
        e_route = r[ROUTE_BITS-1:0];
        m_last_route = e_route;
        m_last_hit   = e_hit;
        if (STATS) begin
          if (e_hit) m_hit = (m_hit == 32'hFFFF_FFFF) ? m_hit : m_hit + 1;
          else       m_miss = (m_miss == 32'hFFFF_FFFF) ? m_miss : m_miss + 1;
        end
        phase = P_WAITLOW;
      end else if (phase == P_WAITLOW && !tx_sid_valid) begin
        phase = P_FREE;
      end else if (phase == P_FREE && tx_sid_valid) begin
        idx = int'(tx_sid) % DEPTH;
        tag = int'(tx_sid) / DEPTH;
        h = m_done && t_valid[idx] && (t_tag[idx] == tag);
        exp_q.push_back({h, h ? t_route[idx] : DEF_ROUTE});
        due_q.push_back(cyc + 2);
        phase = P_BUSY;
      end
      // Table update after the lookup read, so a same-edge write is not seen by it
      if (m_done && cfg_wr_valid) begin
        idx = int'(cfg_wr_sid) % DEPTH;
        t_valid[idx] = !cfg_wr_del;
        t_tag[idx]   = int'(cfg_wr_sid) / DEPTH;
        t_route[idx] = cfg_wr_route;
      end
      if (!m_done) begin
        m_sweep++;
        if (m_sweep == DEPTH) m_done = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int                    d_strobes = 0;
  logic [ROUTE_BITS-1:0] d_route = '0;
  logic                  d_hit = 1'b0;
  int                    d_strobe_cyc = 0;

  always @(negedge aclk) begin
    if (chk_en) begin
      check("strobe",    tx_route_id_valid, e_valid);
      check("route",     tx_route_id,       e_route);
      check("hit",       tx_route_hit,      e_hit);
      check("init_done", init_done,         m_done);
      check("wr_ready",  cfg_wr_ready,      m_done);
      check("hit_cnt",   stat_hit_cnt,      m_hit);
      check("miss_cnt",  stat_miss_cnt,     m_miss);
      if (tx_route_id_valid) begin
        d_strobes++;
        d_route      = tx_route_id;
        d_hit        = tx_route_hit;
        d_strobe_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int rel_cyc = 0;
  int req_cyc = 0;

  task automatic cfg_write(input logic [SID_BITS-1:0] sid, input logic [ROUTE_BITS-1:0] route,
                           input logic del);
    @(negedge aclk);
    cfg_wr_valid = 1'b1;
    cfg_wr_sid   = sid;
    cfg_wr_route = route;
    cfg_wr_del   = del;
    @(negedge aclk);
    cfg_wr_valid = 1'b0;
    cfg_wr_del   = 1'b0;
  endtask

  task automatic lookup(input logic [SID_BITS-1:0] sid, input int hold);
    @(negedge aclk);
    tx_sid_valid = 1'b1;
    tx_sid       = sid;
    req_cyc      = cyc + 1;
    repeat (hold) @(negedge aclk);
    tx_sid_valid = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  task automatic expect_answer(input string name, input int s0, input logic [ROUTE_BITS-1:0] route,
                               input logic hit);
    check({name, "_count"},   d_strobes - s0, 1);
    check({name, "_route"},   d_route, route);
    check({name, "_hitflag"}, d_hit, hit);
    check({name, "_latency"}, d_strobe_cyc - req_cyc, 2);
    check({name, "_model_route"}, m_last_route, route);
    check({name, "_model_hit"},   m_last_hit, hit);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    areset       = 1'b1;
    tx_sid       = '0;
    tx_sid_valid = 1'b0;
    cfg_wr_valid = 1'b0;
    cfg_wr_sid   = '0;
    cfg_wr_route = '0;
    cfg_wr_del   = 1'b0;
    @(posedge aclk);
    #1 chk_en = 1'b1;

    // Reset for 4 cycles, then a lookup while the sweep runs
    repeat (4) @(negedge aclk);
    areset  = 1'b0;
    rel_cyc = cyc;
    check("reset_route", tx_route_id, 0);
    check("reset_ready", cfg_wr_ready, 0);
    s0 = d_strobes;
    lookup(16'h0005, 4);
    expect_answer("sweep_lookup", s0, 14'h0000, 1'b0);

    // init_done rises exactly 1024 edges after release
    while (cyc < rel_cyc + 1023) @(negedge aclk);
    check("init_done_1023", init_done, 0);
    @(negedge aclk);
    check("init_done_1024", init_done, 1);
    check("wr_ready_1024", cfg_wr_ready, 1);

    // Program and hit
    cfg_write(16'h0123, 14'h02A5, 1'b0);
    s0 = d_strobes;
    lookup(16'h0123, 5);
    expect_answer("prog_hit", s0, 14'h02A5, 1'b1);
    check("hit_cnt_1", stat_hit_cnt, STATS ? 32'd1 : 32'd0);

    // Tag miss on the same index
    s0 = d_strobes;
    lookup(16'h0523, 4);
    expect_answer("tag_miss", s0, DEF_ROUTE, 1'b0);
    check("miss_cnt_2", stat_miss_cnt, STATS ? 32'd2 : 32'd0);

    // Delete then look up
    cfg_write(16'h0123, 14'h0000, 1'b1);
    s0 = d_strobes;
    lookup(16'h0123, 3);
    expect_answer("deleted", s0, 14'h0000, 1'b0);

    // Collision: write lands the same edge the lookup read issues
    cfg_write(16'h0040, 14'h00AA, 1'b0);
    @(negedge aclk);
    s0 = d_strobes;
    cfg_wr_valid = 1'b1; cfg_wr_sid = 16'h0040; cfg_wr_route = 14'h0111; cfg_wr_del = 1'b0;
    tx_sid_valid = 1'b1; tx_sid = 16'h0040; req_cyc = cyc + 1;
    @(negedge aclk);
    cfg_wr_valid = 1'b0;
    tx_sid = 16'h0123;
    repeat (3) @(negedge aclk);
    tx_sid_valid = 1'b0;
    repeat (2) @(negedge aclk);
    expect_answer("collide_old", s0, 14'h00AA, 1'b1);
    s0 = d_strobes;
    lookup(16'h0040, 3);
    expect_answer("collide_new", s0, 14'h0111, 1'b1);

    // Hit counter saturation
`ifdef TCP_ROUTE_STATS_EN
    @(negedge aclk);
    dut.hit_cnt = 32'hFFFF_FFFE;
    m_hit       = 32'hFFFF_FFFE;
`endif
    repeat (3) lookup(16'h0040, 3);
    check("hit_cnt_sat", stat_hit_cnt, STATS ? 32'hFFFF_FFFF : 32'd0);
    check("model_hit_sat", m_hit, STATS ? 32'hFFFF_FFFF : 32'd0);

    // Randomized traffic on a small SID pool to force tag conflicts and collisions
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      cfg_wr_valid = ($urandom_range(0, 3) == 0);
      cfg_wr_sid   = SID_BITS'(($urandom_range(0, 3) << IDX_BITS) | $urandom_range(0, 7));
      cfg_wr_route = ROUTE_BITS'($urandom);
      cfg_wr_del   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) tx_sid_valid = ~tx_sid_valid;
      tx_sid = SID_BITS'(($urandom_range(0, 3) << IDX_BITS) | $urandom_range(0, 7));
    end
    @(negedge aclk);
    cfg_wr_valid = 1'b0;
    tx_sid_valid = 1'b0;
    repeat (4) @(negedge aclk);

    // Reset in the middle of a lookup: no strobe, sweep restarts
    s0 = d_strobes;
    tx_sid_valid = 1'b1;
    tx_sid       = 16'h0040;
    @(negedge aclk);
    areset       = 1'b1;
    tx_sid_valid = 1'b0;
    repeat (2) @(negedge aclk);
    areset  = 1'b0;
    rel_cyc = cyc;
    repeat (4) @(negedge aclk);
    check("abort_no_strobe", d_strobes - s0, 0);
    check("abort_init_done", init_done, 0);
    while (cyc < rel_cyc + 1026) @(negedge aclk);
    check("resweep_done", init_done, 1);
    s0 = d_strobes;
    lookup(16'h0040, 3);
    expect_answer("after_resweep", s0, DEF_ROUTE, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
